// File: rtl/pe_array_router_pkg.sv
// Shared types and helpers for the PE-array data-in router.
package pe_array_router_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic {
    SRC_DUMMY = 1'b0,
    SRC_BUFF  = 1'b1
  } src_e;

  localparam int BEAT_CNT_W    = 16;
  localparam int RESET_TAP_CNT = 3;

  function automatic int clamp_int(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pe_row_rotator.sv
// Combinational modular row rotation: data_o[r] = data_i[(r + shift) mod ROWS].
module pe_row_rotator
  import pe_array_router_pkg::*;
#(
  parameter int ROWS      = 16,
  parameter int WIDTH     = 17,
  parameter int MAX_SHIFT = 3,
  parameter int SHIFT_W   = $clog2(MAX_SHIFT + 1)
) (
  input  logic [ROWS*WIDTH-1:0] data_i,
  input  logic [SHIFT_W-1:0]    shift_i,
  output logic [ROWS*WIDTH-1:0] data_o
);

  // NOTE: every variable written in always_comb is assigned before any branch, so no latch can form.
  always_comb begin
    int s;
    s      = clamp_int(int'(shift_i), 0, MAX_SHIFT);
    data_o = '0;
    for (int r = 0; r < ROWS; r++) begin
      data_o[r*WIDTH +: WIDTH] = data_i[((r + s) % ROWS)*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/pe_array_data_in_router.sv
// Registered valid/ready router feeding activations, weight taps and shadow data to the PE array.
module pe_array_data_in_router
  import pe_array_router_pkg::*;
#(
  parameter int NUM_PE_ROW    = 16,
  parameter int NUM_PE_COL    = 16,
  parameter int NB_TAPS       = 11,
  parameter int ACT_WIDTH     = 16,
  parameter int WEIGHT_WIDTH  = 16,
  parameter int ETC_WIDTH     = 4,
  parameter int BPR_WIDTH     = ((WEIGHT_WIDTH + 1) / 2) * 3,
  parameter int MAX_ROW_SHIFT = 3,
  parameter int SHADOW_KEEP   = 7
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          cfg_valid,
  output logic                                          cfg_ready,
  input  logic                                          cfg_act_src,
  input  logic [$clog2(MAX_ROW_SHIFT+1)-1:0]            cfg_row_shift,
  input  logic [$clog2(NB_TAPS+1)-1:0]                  cfg_tap_cnt,
  input  logic                                          cfg_w_src,
  input  logic                                          start,
  input  logic                                          stop,
  output logic                                          busy,
  input  logic [NUM_PE_ROW*(ACT_WIDTH+1)-1:0]           act_dummy,
  input  logic [NUM_PE_ROW*(ACT_WIDTH+1)-1:0]           act_buff,
  input  logic                                          act_in_valid,
  output logic                                          act_in_ready,
  output logic [NUM_PE_ROW*(ACT_WIDTH+1)-1:0]           pe_act,
  output logic                                          pe_act_valid,
  input  logic                                          pe_act_ready,
  input  logic                                          w_load,
  input  logic [NUM_PE_COL*NB_TAPS*WEIGHT_WIDTH-1:0]    w_dummy,
  input  logic [NUM_PE_COL*NB_TAPS*WEIGHT_WIDTH-1:0]    w_buff,
  input  logic [NUM_PE_COL*NB_TAPS*BPR_WIDTH-1:0]       bpr_dummy,
  input  logic [NUM_PE_COL*NB_TAPS*BPR_WIDTH-1:0]       bpr_buff,
  input  logic [NUM_PE_COL*NB_TAPS*ETC_WIDTH-1:0]       etc_dummy,
  input  logic [NUM_PE_COL*NB_TAPS*ETC_WIDTH-1:0]       etc_buff,
  input  logic [NUM_PE_COL*(ACT_WIDTH+1)-1:0]           shd_dummy,
  input  logic [NUM_PE_COL*(ACT_WIDTH+1)-1:0]           shd_buff,
  output logic [NUM_PE_COL*NB_TAPS*WEIGHT_WIDTH-1:0]    WRegs,
  output logic [NUM_PE_COL*NB_TAPS*BPR_WIDTH-1:0]       WBPRs,
  output logic [NUM_PE_COL*NB_TAPS*ETC_WIDTH-1:0]       WETCs,
  output logic [NUM_PE_COL*(ACT_WIDTH+1)-1:0]           pe_shadow,
  output logic [15:0]                                   act_beat_cnt
);

  localparam int CACT_W  = ACT_WIDTH + 1;
  localparam int SHIFT_W = $clog2(MAX_ROW_SHIFT + 1);
  localparam int TAP_W   = $clog2(NB_TAPS + 1);
  localparam int ACT_BUS = NUM_PE_ROW * CACT_W;
  localparam int SHD_BUS = NUM_PE_COL * CACT_W;
  localparam int W_BUS   = NUM_PE_COL * NB_TAPS * WEIGHT_WIDTH;
  localparam int B_BUS   = NUM_PE_COL * NB_TAPS * BPR_WIDTH;
  localparam int E_BUS   = NUM_PE_COL * NB_TAPS * ETC_WIDTH;

  // Shadow lanes keep the compression flag (MSB) and the SHADOW_KEEP low bits.
  localparam logic [CACT_W-1:0] SHD_MASK =
    {1'b1, {(CACT_W-1-SHADOW_KEEP){1'b0}}, {SHADOW_KEEP{1'b1}}};

  state_e                  state_q, state_d;
  src_e                    act_src_q, act_src_d;
  src_e                    w_src_q, w_src_d;
  logic [SHIFT_W-1:0]      row_shift_q, row_shift_d;
  logic [TAP_W-1:0]        tap_cnt_q, tap_cnt_d;
  logic [ACT_BUS-1:0]      pe_act_q, pe_act_d;
  logic                    pe_act_valid_q, pe_act_valid_d;
  logic [BEAT_CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [W_BUS-1:0]        wregs_q, wregs_d;
  logic [B_BUS-1:0]        wbpr_q, wbpr_d;
  logic [E_BUS-1:0]        wetc_q, wetc_d;
  logic [SHD_BUS-1:0]      shadow_q, shadow_d;

  logic                    cfg_take;
  logic                    beat_fire;
  logic [ACT_BUS-1:0]      act_rot;
  logic [ACT_BUS-1:0]      act_sel;

  pe_row_rotator #(
    .ROWS      (NUM_PE_ROW),
    .WIDTH     (CACT_W),
    .MAX_SHIFT (MAX_ROW_SHIFT),
    .SHIFT_W   (SHIFT_W)
  ) u_rotator (
    .data_i  (act_buff),
    .shift_i (row_shift_q),
    .data_o  (act_rot)
  );

  assign act_sel = (act_src_q == SRC_BUFF) ? act_rot : act_dummy;

  // FSM next state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cfg_ready    = 1'b0;
    act_in_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (start) state_d = RUN;
      end
      RUN: begin
        act_in_ready = !pe_act_valid_q || pe_act_ready;
        if (stop) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pe_act_valid_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cfg_take  = cfg_ready && cfg_valid;
  assign beat_fire = act_in_valid && act_in_ready;
  assign busy      = (state_q != IDLE);

  // Config capture; illegal tap counts are clamped into 1..NB_TAPS here.
  always_comb begin
    act_src_d   = act_src_q;
    w_src_d     = w_src_q;
    row_shift_d = row_shift_q;
    tap_cnt_d   = tap_cnt_q;
    if (cfg_take) begin
      act_src_d   = src_e'(cfg_act_src);
      w_src_d     = src_e'(cfg_w_src);
      row_shift_d = cfg_row_shift;
      tap_cnt_d   = TAP_W'(clamp_int(int'(cfg_tap_cnt), 1, NB_TAPS));
    end
  end

  // Single-entry output stage: a beat holds on pe_act until the PE array pops it.
  always_comb begin
    pe_act_d       = pe_act_q;
    pe_act_valid_d = pe_act_valid_q;
    beat_cnt_d     = beat_cnt_q;
    if (beat_fire) begin
      pe_act_d       = act_sel;
      pe_act_valid_d = 1'b1;
    end else if (pe_act_ready) begin
      pe_act_valid_d = 1'b0;
    end
    if (state_q == IDLE && start) begin
      beat_cnt_d = '0;
    end else if (beat_fire && beat_cnt_q != {BEAT_CNT_W{1'b1}}) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end
  end

  // Weight/BPR/ETC taps at or above the active tap count load as zero.
  always_comb begin
    wregs_d  = wregs_q;
    wbpr_d   = wbpr_q;
    wetc_d   = wetc_q;
    shadow_d = shadow_q;
    if (w_load) begin
      for (int c = 0; c < NUM_PE_COL; c++) begin
        for (int t = 0; t < NB_TAPS; t++) begin
          if (t < int'(tap_cnt_q)) begin
            wregs_d[(c*NB_TAPS+t)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = (w_src_q == SRC_BUFF)
              ? w_buff[(c*NB_TAPS+t)*WEIGHT_WIDTH +: WEIGHT_WIDTH]
              : w_dummy[(c*NB_TAPS+t)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            wbpr_d[(c*NB_TAPS+t)*BPR_WIDTH +: BPR_WIDTH] = (w_src_q == SRC_BUFF)
              ? bpr_buff[(c*NB_TAPS+t)*BPR_WIDTH +: BPR_WIDTH]
              : bpr_dummy[(c*NB_TAPS+t)*BPR_WIDTH +: BPR_WIDTH];
            wetc_d[(c*NB_TAPS+t)*ETC_WIDTH +: ETC_WIDTH] = (w_src_q == SRC_BUFF)
              ? etc_buff[(c*NB_TAPS+t)*ETC_WIDTH +: ETC_WIDTH]
              : etc_dummy[(c*NB_TAPS+t)*ETC_WIDTH +: ETC_WIDTH];
          end else begin
            wregs_d[(c*NB_TAPS+t)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = '0;
            wbpr_d[(c*NB_TAPS+t)*BPR_WIDTH +: BPR_WIDTH]        = '0;
            wetc_d[(c*NB_TAPS+t)*ETC_WIDTH +: ETC_WIDTH]        = '0;
          end
        end
        shadow_d[c*CACT_W +: CACT_W] = SHD_MASK & ((w_src_q == SRC_BUFF)
          ? shd_buff[c*CACT_W +: CACT_W] : shd_dummy[c*CACT_W +: CACT_W]);
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the tap and shadow banks are plain flops, not RAM, so they reset to zero along with control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      act_src_q      <= SRC_DUMMY;
      w_src_q        <= SRC_DUMMY;
      row_shift_q    <= '0;
      tap_cnt_q      <= TAP_W'(RESET_TAP_CNT);
      pe_act_q       <= '0;
      pe_act_valid_q <= 1'b0;
      beat_cnt_q     <= '0;
      wregs_q        <= '0;
      wbpr_q         <= '0;
      wetc_q         <= '0;
      shadow_q       <= '0;
    end else begin
      state_q        <= state_d;
      act_src_q      <= act_src_d;
      w_src_q        <= w_src_d;
      row_shift_q    <= row_shift_d;
      tap_cnt_q      <= tap_cnt_d;
      pe_act_q       <= pe_act_d;
      pe_act_valid_q <= pe_act_valid_d;
      beat_cnt_q     <= beat_cnt_d;
      wregs_q        <= wregs_d;
      wbpr_q         <= wbpr_d;
      wetc_q         <= wetc_d;
      shadow_q       <= shadow_d;
    end
  end

  assign pe_act       = pe_act_q;
  assign pe_act_valid = pe_act_valid_q;
  assign act_beat_cnt = beat_cnt_q;
  assign WRegs        = wregs_q;
  assign WBPRs        = wbpr_q;
  assign WETCs        = wetc_q;
  assign pe_shadow    = shadow_q;

endmodule

// File: tb/tb_pe_array_data_in_router.sv
// Self-checking bench for pe_array_data_in_router: vector tables, stall/drain/reset sequences, beat scoreboard.
module tb_pe_array_data_in_router;

  localparam int R  = 16;
  localparam int C  = 16;
  localparam int T  = 11;
  localparam int CW = 17;
  localparam int WW = 16;
  localparam int BW = 24;
  localparam int EW = 4;
  localparam int AV = R * CW;
  localparam int SV = C * CW;
  localparam int WV = C * T * WW;
  localparam int BV = C * T * BW;
  localparam int EV = C * T * EW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready, cfg_act_src, cfg_w_src;
  logic [1:0]    cfg_row_shift;
  logic [3:0]    cfg_tap_cnt;
  logic          start, stop, busy;
  logic [AV-1:0] act_dummy, act_buff, pe_act;
  logic          act_in_valid, act_in_ready, pe_act_valid, pe_act_ready;
  logic          w_load;
  logic [WV-1:0] w_dummy, w_buff, WRegs;
  logic [BV-1:0] bpr_dummy, bpr_buff, WBPRs;
  logic [EV-1:0] etc_dummy, etc_buff, WETCs;
  logic [SV-1:0] shd_dummy, shd_buff, pe_shadow;
  logic [15:0]   act_beat_cnt;

  int checks = 0;
  int errors = 0;
  logic [AV-1:0] exp_q[$];
  logic          m_src;
  logic [1:0]    m_shift;

  pe_array_data_in_router dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_act_src(cfg_act_src),
    .cfg_row_shift(cfg_row_shift), .cfg_tap_cnt(cfg_tap_cnt), .cfg_w_src(cfg_w_src),
    .start(start), .stop(stop), .busy(busy),
    .act_dummy(act_dummy), .act_buff(act_buff),
    .act_in_valid(act_in_valid), .act_in_ready(act_in_ready),
    .pe_act(pe_act), .pe_act_valid(pe_act_valid), .pe_act_ready(pe_act_ready),
    .w_load(w_load), .w_dummy(w_dummy), .w_buff(w_buff),
    .bpr_dummy(bpr_dummy), .bpr_buff(bpr_buff),
    .etc_dummy(etc_dummy), .etc_buff(etc_buff),
    .shd_dummy(shd_dummy), .shd_buff(shd_buff),
    .WRegs(WRegs), .WBPRs(WBPRs), .WETCs(WETCs),
    .pe_shadow(pe_shadow), .act_beat_cnt(act_beat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Wide buses: report only the first differing 16-bit chunk.
  task automatic check_bus(input string name, input logic [BV-1:0] act, input logic [BV-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < BV / 16; i++) begin
        if (act[i*16 +: 16] !== exp[i*16 +: 16]) begin
          $display("FAIL %s: chunk %0d got %h expected %h", name, i, act[i*16 +: 16], exp[i*16 +: 16]);
          break;
        end
      end
    end
  endtask

  function automatic logic [AV-1:0] model_act(input logic src, input logic [1:0] sh,
                                              input logic [AV-1:0] buff, input logic [AV-1:0] dmy);
    logic [AV-1:0] o;
    int s;
    s = (int'(sh) > 3) ? 3 : int'(sh);
    for (int r = 0; r < R; r++)
      o[r*CW +: CW] = src ? buff[((r + s) % R)*CW +: CW] : dmy[r*CW +: CW];
    return o;
  endfunction

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    logic [AV-1:0] e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (pe_act_valid && pe_act_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: unexpected beat %h", pe_act[63:0]);
        end else begin
          e = exp_q.pop_front();
          check_bus("sb_pe_act", BV'(pe_act), BV'(e));
        end
      end
      if (act_in_valid && act_in_ready)
        exp_q.push_back(model_act(m_src, m_shift, act_buff, act_dummy));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_act(input logic [16:0] base);
    for (int r = 0; r < R; r++) begin
      act_buff[r*CW +: CW]  = base + 17'(r);
      act_dummy[r*CW +: CW] = 17'h01000 + 17'(r);
    end
  endtask

  // Issued only while the DUT is IDLE, so the bench's config model follows it.
  task automatic configure(input logic src, input logic [1:0] sh, input logic [3:0] taps,
                           input logic wsrc, input logic go);
    cfg_valid = 1'b1; cfg_act_src = src; cfg_row_shift = sh; cfg_tap_cnt = taps;
    cfg_w_src = wsrc; start = go;
    m_src = src; m_shift = sh;
    step();
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check(name, 64'(busy), 64'd0);
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("stop_to_idle");
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 64'(pe_act_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'd1);
    check({tag, "_cnt"}, 64'(act_beat_cnt), 64'd0);
    check_bus({tag, "_wregs"}, BV'(WRegs), '0);
    check_bus({tag, "_shadow"}, BV'(pe_shadow), '0);
  endtask

  task automatic check_weights(input string tag, input int ntaps, input logic wsrc);
    logic [WV-1:0] ew;
    logic [BV-1:0] eb;
    logic [EV-1:0] ee;
    logic [SV-1:0] es;
    for (int i = 0; i < C * T; i++) begin
      ew[i*WW +: WW] = ((i % T) < ntaps) ? (wsrc ? 16'hFFFF : 16'h5A5A) : 16'h0;
      eb[i*BW +: BW] = ((i % T) < ntaps) ? (wsrc ? 24'hFFFFFF : 24'h0F0F0F) : 24'h0;
      ee[i*EW +: EW] = ((i % T) < ntaps) ? (wsrc ? 4'hF : 4'h5) : 4'h0;
    end
    for (int c = 0; c < C; c++) es[c*CW +: CW] = wsrc ? 17'h1007F : 17'h0002A;
    check_bus({tag, "_wregs"}, BV'(WRegs), BV'(ew));
    check_bus({tag, "_wbprs"}, WBPRs, eb);
    check_bus({tag, "_wetcs"}, BV'(WETCs), BV'(ee));
    check_bus({tag, "_shadow"}, BV'(pe_shadow), BV'(es));
  endtask

  typedef struct {
    logic        src;
    logic [1:0]  shift;
    logic [16:0] base;
    logic [16:0] exp0;
    logic [16:0] exp15;
  } act_vec_t;

  typedef struct {
    logic [3:0] taps_in;
    logic       wsrc;
    int         exp_taps;
  } w_vec_t;

  act_vec_t avec[5];
  w_vec_t   wvec[4];

  initial begin
    logic [AV-1:0] exp_a;

    avec[0] = '{1'b1, 2'd2, 17'h00001, 17'h00003, 17'h00002};
    avec[1] = '{1'b1, 2'd0, 17'h00020, 17'h00020, 17'h0002F};
    avec[2] = '{1'b1, 2'd3, 17'h00100, 17'h00103, 17'h00102};
    avec[3] = '{1'b0, 2'd3, 17'h00500, 17'h01000, 17'h0100F};
    avec[4] = '{1'b1, 2'd1, 17'h1FFF0, 17'h1FFF1, 17'h1FFF0};

    wvec[0] = '{4'd3,  1'b1, 3};
    wvec[1] = '{4'd0,  1'b1, 1};
    wvec[2] = '{4'd15, 1'b1, 11};
    wvec[3] = '{4'd11, 1'b0, 11};

    rst = 1'b1; cfg_valid = 1'b0; cfg_act_src = 1'b0; cfg_row_shift = '0; cfg_tap_cnt = 4'd3;
    cfg_w_src = 1'b0; start = 1'b0; stop = 1'b0; act_in_valid = 1'b0; pe_act_ready = 1'b1;
    w_load = 1'b0; m_src = 1'b0; m_shift = '0;
    fill_act(17'h0);
    w_buff = {WV{1'b1}};   w_dummy = {(C*T){16'h5A5A}};
    bpr_buff = {BV{1'b1}}; bpr_dummy = {(C*T){24'h0F0F0F}};
    etc_buff = {EV{1'b1}}; etc_dummy = {(C*T){4'h5}};
    shd_buff = {C{17'h1FFFF}}; shd_dummy = {C{17'h0AAAA}};
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("por");
    step();

    // Activation routing table: config+start together, one beat, latency 1.
    foreach (avec[i]) begin
      fill_act(avec[i].base);
      configure(avec[i].src, avec[i].shift, 4'd3, 1'b0, 1'b1);
      act_in_valid = 1'b1; pe_act_ready = 1'b1;
      step();
      act_in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("act%0d_latency", i), 64'(pe_act_valid), 64'd1);
      check($sformatf("act%0d_lane0", i), 64'(pe_act[0 +: CW]), 64'(avec[i].exp0));
      check($sformatf("act%0d_lane15", i), 64'(pe_act[15*CW +: CW]), 64'(avec[i].exp15));
      check($sformatf("act%0d_cnt", i), 64'(act_beat_cnt), 64'd1);
      step();
      stop_run();
    end

    // Output stall: input blocked, beat held, nothing lost.
    fill_act(17'h00040);
    configure(1'b1, 2'd0, 4'd3, 1'b0, 1'b1);
    pe_act_ready = 1'b0; act_in_valid = 1'b1;
    step();
    exp_a = model_act(1'b1, 2'd0, act_buff, act_dummy);
    fill_act(17'h00080);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_in_ready", k), 64'(act_in_ready), 64'd0);
      check_bus($sformatf("stall%0d_hold", k), BV'(pe_act), BV'(exp_a));
      step();
    end
    pe_act_ready = 1'b1;
    @(negedge clk);
    check("stall_release_in_ready", 64'(act_in_ready), 64'd1);
    step();
    act_in_valid = 1'b0;
    @(negedge clk);
    check("stall_second_valid", 64'(pe_act_valid), 64'd1);
    step();
    @(negedge clk);
    check("stall_empty", 64'(pe_act_valid), 64'd0);
    check("stall_cnt", 64'(act_beat_cnt), 64'd2);
    step();
    stop_run();

    // Stop while stalled: DRAIN holds until the pop, rejects config.
    fill_act(17'h00200);
    configure(1'b1, 2'd1, 4'd3, 1'b0, 1'b1);
    pe_act_ready = 1'b0; act_in_valid = 1'b1;
    step();
    act_in_valid = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    act_in_valid = 1'b1; cfg_valid = 1'b1; cfg_row_shift = 2'd3; cfg_act_src = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("drain%0d_busy", k), 64'(busy), 64'd1);
      check($sformatf("drain%0d_in_ready", k), 64'(act_in_ready), 64'd0);
      check($sformatf("drain%0d_cfg_ready", k), 64'(cfg_ready), 64'd0);
      step();
    end
    cfg_valid = 1'b0; act_in_valid = 1'b0; pe_act_ready = 1'b1;
    step();
    wait_idle("drain_to_idle");
    start = 1'b1;
    step();
    start = 1'b0;
    fill_act(17'h00300);
    act_in_valid = 1'b1;
    step();
    act_in_valid = 1'b0;
    @(negedge clk);
    check("post_drain_cfg_kept", 64'(pe_act[0 +: CW]), 64'h301);
    step();
    stop_run();

    // Weight/shadow load table.
    foreach (wvec[i]) begin
      configure(1'b0, 2'd0, wvec[i].taps_in, wvec[i].wsrc, 1'b0);
      w_load = 1'b1;
      step();
      w_load = 1'b0;
      @(negedge clk);
      check_weights($sformatf("w%0d", i), wvec[i].exp_taps, wvec[i].wsrc);
      step();
    end
    configure(1'b0, 2'd0, 4'd3, 1'b1, 1'b0);
    w_load = 1'b1;
    step();
    w_load = 1'b0;
    w_buff = '0; shd_buff = '0;
    step();
    @(negedge clk);
    check_weights("w_hold", 3, 1'b1);
    step();

    // Reset mid-RUN with a beat in flight.
    fill_act(17'h00400);
    configure(1'b1, 2'd0, 4'd3, 1'b1, 1'b1);
    pe_act_ready = 1'b0; act_in_valid = 1'b1;
    step();
    act_in_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", 64'(pe_act_valid), 64'd1);
    step();
    rst = 1'b1; m_src = 1'b0; m_shift = '0;
    step();
    rst = 1'b0; pe_act_ready = 1'b1;
    @(negedge clk);
    check_reset_state("midrun");
    step();

    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
